cla_multiword_seq: RTL
======================

Name: cla_multiword_seq

Overview:
Sequencer that performs wide add/subtract by time-multiplexing one narrow carry_lookahead_adder over CHUNKS slices, least-significant slice first. It registers the inter-slice carry and accumulates the result slices. It sits between a valid/ready producer and consumer in the posit datapath, where wide mantissa/exponent arithmetic must not cost a full-width adder.

Parameters:
WIDTH, 8, slice width in bits; the internal adder instance is WIDTH+1 bits wide.
CHUNKS, 4, number of slices; total operand width N = WIDTH*CHUNKS; legal range 1..64.

Ports:
i_clk  input  1  clock.
i_rst  input  1  synchronous, active-high reset.
i_valid  input  1  operand request valid.
o_ready  output  1  block can accept a request (high only in IDLE).
i_add1  input  N  operand A, unsigned.
i_add2  input  N  operand B, unsigned.
i_sub  input  1  0 = A+B, 1 = A-B.
o_valid  output  1  result valid (high only in DONE).
i_ready  input  1  consumer accepts result.
o_result  output  N+1  bit N = final carry-out; bits N-1:0 = sum/difference.
o_busy  output  1  high in RUN.

Behaviour:
- Reset: synchronous on i_clk while i_rst=1. Reset values: state=IDLE, o_ready=1, o_valid=0, o_busy=0, o_result=0, carry=0, slice index=0. Reset wins over every other event, including mid-RUN and DONE; any in-flight operation is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE: o_ready=1.
  - On i_valid=1, capture A into the A register.
  - Capture B ^ {N{i_sub}} into the B register.
  - Set carry <= i_sub and idx <= 0, then go to RUN.
- RUN: each cycle processes slice idx.
  - Adder operands are {A[idx], 1'b1} and {B[idx], carry}, where A[idx] and B[idx] are the WIDTH-bit slices at idx.
  - Adder result r is WIDTH+2 bits. The slice sum is r[WIDTH:1]; the slice carry-out is r[WIDTH+1]. The LSB trick injects carry-in without a carry-in port.
  - Write the slice sum to o_result[idx*WIDTH +: WIDTH] and set carry <= r[WIDTH+1].
  - If idx == CHUNKS-1: set o_result[N] <= r[WIDTH+1] and go to DONE. Otherwise idx <= idx+1.
- DONE: o_valid=1; o_result is held stable.
  - On i_ready=1, go to IDLE.
  - i_valid is ignored in DONE; there is no back-to-back accept and no combinational ready path.
- Latency: with the accept edge at T0, o_valid rises after edge T0+CHUNKS, i.e. CHUNKS+1 cycles from the request cycle. Throughput is one operation per CHUNKS+2 cycles minimum.
- o_result bits are undefined-free. Slices not yet written keep their prior value during RUN, and consumers may sample o_result only while o_valid=1.
- Subtraction result is two's complement modulo 2^N. o_result[N]=1 means A>=B (no borrow); o_result[N]=0 means borrow.
- Index counter width is max(1,$clog2(CHUNKS)). With CHUNKS=1, RUN lasts exactly one cycle.
- i_add1, i_add2 and i_sub are sampled only at the accept edge. Changes at any other time have no effect.
- The adder path is purely combinational between registers, so the critical path is one (WIDTH+1)-bit CLA.

Decomposition:
- Package cla_seq_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;
  - localparam function for the index width.
- Sub-module: one instance of the existing carry_lookahead_adder #(.WIDTH(WIDTH+1)). No other sub-modules; the FSM, slice mux and result registers live in cla_multiword_seq.

Test Plan:
All scenarios use the defaults WIDTH=8, CHUNKS=4 unless stated.
1. Add 0x000000FF + 0x00000001, i_sub=0 -> o_result=0x0_00000100. o_valid rises exactly 5 cycles after i_valid is first sampled; o_busy is high for exactly 4 cycles.
2. Add 0xFFFFFFFF + 0x00000001 -> o_result=0x1_00000000; the carry ripples through all 4 slices.
3. Sub 0x00000005 - 0x00000007 -> 0x0_FFFFFFFE (borrow). Sub 0x00001000 - 0x00000001 -> 0x1_00000FFF.
4. Backpressure: hold i_ready=0 for 5 cycles in DONE while pulsing i_valid with new operands. Required: o_valid stays 1, o_result is unchanged, o_ready stays 0, and the new request is not captured. Raising i_ready gives IDLE next cycle.
5. Assert i_rst for 1 cycle after 2 RUN cycles of 0xAAAAAAAA+0x55555555. Required: the next cycle is IDLE with o_ready=1, o_valid=0, o_result=0. A following 0x12345678+0x11111111 gives 0x0_23456789.
6. CHUNKS=1, WIDTH=8: 0xFF+0xFF -> 0x1FE with o_valid 2 cycles after request. Random regression of 1000 add/sub ops at the defaults must match a golden model of {carry, (A±B) mod 2^32}.

Source files
------------

// File: rtl/cla_seq_pkg.sv
// Shared types and sizing helpers for the multi-word carry-lookahead sequencer.
package cla_seq_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;

  // A one-slice configuration still needs a 1-bit index register.
  function automatic int idx_width(input int chunks);
    return (chunks > 1) ? $clog2(chunks) : 1;
  endfunction

endpackage

// File: rtl/carry_lookahead_adder.sv
// Unsigned WIDTH-bit carry-lookahead adder with no carry-in; o_sum MSB is the carry-out.
module carry_lookahead_adder #(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH:0]   sum_o
);

  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] prop;
  logic [WIDTH:0]   carry;
  logic             term;

  // Each carry is the flattened OR of generate terms propagated up to that bit.
  always_comb begin
    gen   = a_i & b_i;
    prop  = a_i ^ b_i;
    carry = '0;
    term  = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j <= i; j++) begin
        term = gen[j];
        for (int k = j + 1; k <= i; k++) begin
          term = term & prop[k];
        end
        carry[i+1] = carry[i+1] | term;
      end
    end
  end

  assign sum_o = {carry[WIDTH], prop ^ carry[WIDTH-1:0]};

endmodule

// File: rtl/cla_multiword_seq.sv
// Wide add/subtract built by stepping one (WIDTH+1)-bit CLA across CHUNKS slices, LSB slice first.
module cla_multiword_seq
  import cla_seq_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int CHUNKS = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [WIDTH*CHUNKS-1:0]    i_add1,
  input  logic [WIDTH*CHUNKS-1:0]    i_add2,
  input  logic                       i_sub,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [WIDTH*CHUNKS:0]      o_result,
  output logic                       o_busy
);

  localparam int N     = WIDTH * CHUNKS;
  localparam int IDX_W = idx_width(CHUNKS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

  seq_state_t state_q, state_d;

  logic [N-1:0]     a_q, a_d;
  logic [N-1:0]     b_q, b_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N:0]       res_q, res_d;

  logic [WIDTH-1:0] a_slice;
  logic [WIDTH-1:0] b_slice;
  logic [WIDTH+1:0] add_r;
  logic [WIDTH-1:0] slice_sum;
  logic             slice_cout;
  logic             unused_add_lsb;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_valid)          state_d = RUN;
      RUN:     if (idx_q == LAST_IDX) state_d = DONE;
      DONE:    if (i_ready)          state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  // Handshake outputs are decoded from state only, so there is no ready/valid comb path.
  always_comb begin
    o_ready = 1'b0;
    o_valid = 1'b0;
    o_busy  = 1'b0;
    case (state_q)
      IDLE:    o_ready = 1'b1;
      RUN:     o_busy  = 1'b1;
      DONE:    o_valid = 1'b1;
      default: ;
    endcase
  end

  assign a_slice = a_q[idx_q*WIDTH +: WIDTH];
  assign b_slice = b_q[idx_q*WIDTH +: WIDTH];

  // A constant 1 in the LSB of operand A turns the B-side LSB (carry) into a carry-in.
  carry_lookahead_adder #(.WIDTH(WIDTH + 1)) u_cla (
    .a_i   ({a_slice, 1'b1}),
    .b_i   ({b_slice, carry_q}),
    .sum_o (add_r)
  );

  assign slice_sum      = add_r[WIDTH:1];
  assign slice_cout     = add_r[WIDTH+1];
  assign unused_add_lsb = add_r[0];

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    res_d   = res_q;
    if (state_q == IDLE && i_valid) begin
      a_d     = i_add1;
      b_d     = i_add2 ^ {N{i_sub}};
      carry_d = i_sub;
      idx_d   = '0;
    end else if (state_q == RUN) begin
      res_d[idx_q*WIDTH +: WIDTH] = slice_sum;
      carry_d = slice_cout;
      if (idx_q == LAST_IDX) res_d[N] = slice_cout;
      else                   idx_d    = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      carry_q <= 1'b0;
      idx_q   <= '0;
      res_q   <= '0;
    end else begin
      carry_q <= carry_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
    end
  end

  // Operand registers are only read after a capture, so they carry no reset.
  always_ff @(posedge i_clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign o_result = res_q;

endmodule
